// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// func3 operation encodings and the control FSM state encoding.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle shift-add
// multiply and restoring divide on operand magnitudes.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MINNEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e state, state_nx;
  op_e    op_q, op_in;

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi, lo, bq;
  logic            neg_q, rneg_q;

  logic            sg1, sg2, s1, s2;
  logic            is_div, div0, ovf, special;
  logic            accept, last;
  logic [XLEN-1:0] m1, m2, spec_res;

  logic [XLEN-1:0]   addend;
  logic [XLEN:0]     sum, trial;
  logic              ge;
  logic [XLEN-1:0]   hi_n, lo_n;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   qv, rv, fin;

  assign op_in     = op_e'(func3);
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_comb begin
    sg1 = 1'b0;
    sg2 = 1'b0;
    unique case (op_in)
      OP_MULH, OP_DIV, OP_REM: begin
        sg1 = 1'b1;
        sg2 = 1'b1;
      end
      OP_MULHSU: sg1 = 1'b1;
      default: ;
    endcase
  end

  assign s1     = sg1 & operand1[XLEN-1];
  assign s2     = sg2 & operand2[XLEN-1];
  assign m1     = s1 ? -operand1 : operand1;
  assign m2     = s2 ? -operand2 : operand2;
  assign is_div = func3[2];
  assign div0   = is_div && (operand2 == '0);
  assign ovf    = is_div && sg2
                  && (operand1 == MINNEG)
                  && (&operand2);
  assign special = div0 | ovf;

  // func3[1] distinguishes REM/REMU from DIV/DIVU
  always_comb begin
    spec_res = '0;
    if (div0)
      spec_res = func3[1] ? operand1 : '1;
    else
      spec_res = func3[1] ? '0 : operand1;
  end

  assign accept = in_valid && in_ready && !flush;
  assign last   = (cnt == LAST);

  // One iteration: hi:lo is the product or the remainder:dividend pair
  always_comb begin
    addend = lo[0] ? bq : '0;
    sum    = {1'b0, hi} + {1'b0, addend};
    trial  = {hi, lo[XLEN-1]} - {1'b0, bq};
    ge     = ~trial[XLEN];
    if (op_q[2]) begin
      hi_n = ge ? trial[XLEN-1:0]
                : {hi[XLEN-2:0], lo[XLEN-1]};
      lo_n = {lo[XLEN-2:0], ge};
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo[XLEN-1:1]};
    end
  end

  always_comb begin
    prod = {hi_n, lo_n};
    if (neg_q)
      prod = -prod;
    qv  = neg_q ? -lo_n : lo_n;
    rv  = rneg_q ? -hi_n : hi_n;
    fin = '0;
    unique case (1'b1)
      (op_q == OP_MUL):
        fin = prod[XLEN-1:0];
      (op_q inside {OP_MULH, OP_MULHSU, OP_MULHU}):
        fin = prod[2*XLEN-1:XLEN];
      (op_q inside {OP_DIV, OP_DIVU}):
        fin = qv;
      (op_q inside {OP_REM, OP_REMU}):
        fin = rv;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (accept)
          state_nx = special ? S_DONE : S_CALC;
      S_CALC:
        if (flush)
          state_nx = S_IDLE;
        else if (last)
          state_nx = S_DONE;
      S_DONE:
        if (flush || out_ready)
          state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_MUL;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      bq     <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      result <= '0;
    end else begin
      unique case (state)
        S_IDLE:
          if (accept) begin
            op_q   <= op_in;
            cnt    <= '0;
            hi     <= '0;
            lo     <= is_div ? m1 : m2;
            bq     <= is_div ? m2 : m1;
            neg_q  <= s1 ^ s2;
            rneg_q <= s1;
            if (special)
              result <= spec_res;
          end
        S_CALC: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt + CW'(1);
          if (last)
            result <= fin;
        end
        default: ;
      endcase
      // Result reads as zero whenever the unit is idle
      if (state_nx == S_IDLE)
        result <= '0;
    end
  end

endmodule
